// File: rtl/ascii_operand_parser.sv
// ASCII operand parser: turns "A+B=" / "A+B<CR>" character streams into two
// two-digit ASCII operands. Optional character echo is enabled by PARSER_ECHO_EN.
module ascii_operand_parser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [6:0] AU,
    output logic [6:0] AD,
    output logic [6:0] BU,
    output logic [6:0] BD,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       err,
    output logic [6:0] echo_char,
    output logic       echo_valid
);

    localparam logic [1:0] A_DIG    = 2'd0;
    localparam logic [1:0] B_DIG    = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] ERR_SKIP = 2'd3;

    localparam logic [6:0] ASCII_ZERO = 7'h30;

    logic [1:0] state;
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;

    logic is_digit;
    logic is_space;
    logic is_plus;
    logic is_term;
    logic accept;

    assign is_digit = (char_in >= 7'h30) && (char_in <= 7'h39);
    assign is_space = (char_in == 7'h20);
    assign is_plus  = (char_in == 7'h2B);
    assign is_term  = (char_in == 7'h3D) || (char_in == 7'h0D);

    // Never accept while reset is asserted or while a pair waits downstream.
    assign char_ready = rst_n && (state != HOLD);
    assign accept     = char_valid && char_ready;
    assign op_valid   = (state == HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= A_DIG;
            a_cnt <= 2'd0;
            b_cnt <= 2'd0;
            AU    <= ASCII_ZERO;
            AD    <= ASCII_ZERO;
            BU    <= ASCII_ZERO;
            BD    <= ASCII_ZERO;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                A_DIG: begin
                    if (accept && !is_space) begin
                        if (is_digit && (a_cnt < 2'd2)) begin
                            AU    <= char_in;
                            AD    <= (a_cnt == 2'd0) ? ASCII_ZERO : AU;
                            a_cnt <= a_cnt + 2'd1;
                        end else if (is_plus && (a_cnt != 2'd0)) begin
                            state <= B_DIG;
                        end else begin
                            state <= ERR_SKIP;
                            err   <= 1'b1;
                        end
                    end
                end
                B_DIG: begin
                    if (accept && !is_space) begin
                        if (is_digit && (b_cnt < 2'd2)) begin
                            BU    <= char_in;
                            BD    <= (b_cnt == 2'd0) ? ASCII_ZERO : BU;
                            b_cnt <= b_cnt + 2'd1;
                        end else if (is_term && (b_cnt != 2'd0)) begin
                            state <= HOLD;
                        end else begin
                            state <= ERR_SKIP;
                            err   <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (op_ready) begin
                        state <= A_DIG;
                        a_cnt <= 2'd0;
                        b_cnt <= 2'd0;
                    end
                end
                ERR_SKIP: begin
                    // Resynchronise on the next terminator; everything else is dropped.
                    if (accept && is_term) begin
                        state <= A_DIG;
                        a_cnt <= 2'd0;
                        b_cnt <= 2'd0;
                    end
                end
            endcase
        end
    end

`ifdef PARSER_ECHO_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_valid <= 1'b0;
            echo_char  <= 7'h00;
        end else begin
            echo_valid <= accept;
            if (accept) begin
                echo_char <= char_in;
            end
        end
    end
`else
    assign echo_valid = 1'b0;
    assign echo_char  = 7'h00;
`endif

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Directed self-checking bench for ascii_operand_parser.
// Echo expectations follow PARSER_ECHO_EN as defined for the build.
module tb_ascii_operand_parser;

    logic       clk;
    logic       rst_n;
    logic [6:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] AU;
    logic [6:0] AD;
    logic [6:0] BU;
    logic [6:0] BD;
    logic       op_valid;
    logic       op_ready;
    logic       err;
    logic [6:0] echo_char;
    logic       echo_valid;

    int checks = 0;
    int errors = 0;

`ifdef PARSER_ECHO_EN
    localparam bit ECHO_ON = 1'b1;
`else
    localparam bit ECHO_ON = 1'b0;
`endif

    ascii_operand_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .AU         (AU),
        .AD         (AD),
        .BU         (BU),
        .BD         (BD),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .err        (err),
        .echo_char  (echo_char),
        .echo_valid (echo_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Present one character for one edge; char_valid stays high so strings stream back to back.
    task automatic apply_stimulus(input logic [6:0] c);
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        char_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic take_operands();
        @(negedge clk);
        char_valid = 1'b0;
        op_ready   = 1'b1;
        @(posedge clk);
        #1;
        check_output("take_op_valid", {6'd0, op_valid}, 7'd0);
        check_output("take_char_ready", {6'd0, char_ready}, 7'd1);
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        char_in    = 7'h00;
        char_valid = 1'b0;
        op_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_char_ready", {6'd0, char_ready}, 7'd0);
        check_output("rst_op_valid", {6'd0, op_valid}, 7'd0);
        check_output("rst_err", {6'd0, err}, 7'd0);
        check_output("rst_AU", AU, 7'h30);
        check_output("rst_AD", AD, 7'h30);
        check_output("rst_BU", BU, 7'h30);
        check_output("rst_BD", BD, 7'h30);
        check_output("rst_echo_valid", {6'd0, echo_valid}, 7'd0);
        check_output("rst_echo_char", echo_char, 7'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_rst_char_ready", {6'd0, char_ready}, 7'd1);

        // "12+34=" held in HOLD, then taken
        apply_stimulus(7'h31);
        apply_stimulus(7'h32);
        idle(2);
        check_output("idle_op_valid", {6'd0, op_valid}, 7'd0);
        check_output("idle_AU", AU, 7'h32);
        apply_stimulus(7'h2B);
        apply_stimulus(7'h33);
        apply_stimulus(7'h34);
        apply_stimulus(7'h3D);
        check_output("t1_op_valid", {6'd0, op_valid}, 7'd1);
        check_output("t1_AD", AD, 7'h31);
        check_output("t1_AU", AU, 7'h32);
        check_output("t1_BD", BD, 7'h33);
        check_output("t1_BU", BU, 7'h34);
        check_output("t1_char_ready", {6'd0, char_ready}, 7'd0);
        apply_stimulus(7'h35);
        apply_stimulus(7'h36);
        check_output("t1_hold_op_valid", {6'd0, op_valid}, 7'd1);
        check_output("t1_hold_AU", AU, 7'h32);
        check_output("t1_hold_BU", BU, 7'h34);
        take_operands();
        check_output("t1_after_AU", AU, 7'h32);

        // "7 + 5<CR>"
        apply_stimulus(7'h37);
        apply_stimulus(7'h20);
        apply_stimulus(7'h2B);
        apply_stimulus(7'h20);
        apply_stimulus(7'h35);
        apply_stimulus(7'h0D);
        check_output("t2_op_valid", {6'd0, op_valid}, 7'd1);
        check_output("t2_AD", AD, 7'h30);
        check_output("t2_AU", AU, 7'h37);
        check_output("t2_BD", BD, 7'h30);
        check_output("t2_BU", BU, 7'h35);
        check_output("t2_err", {6'd0, err}, 7'd0);
        take_operands();

        // "123+4=" is rejected at the third digit, then "9+9=" parses
        apply_stimulus(7'h31);
        apply_stimulus(7'h32);
        check_output("t3_err_before", {6'd0, err}, 7'd0);
        apply_stimulus(7'h33);
        check_output("t3_err_pulse", {6'd0, err}, 7'd1);
        apply_stimulus(7'h2B);
        check_output("t3_err_one_cycle", {6'd0, err}, 7'd0);
        apply_stimulus(7'h34);
        apply_stimulus(7'h3D);
        check_output("t3_op_valid", {6'd0, op_valid}, 7'd0);
        check_output("t3_char_ready", {6'd0, char_ready}, 7'd1);
        apply_stimulus(7'h39);
        apply_stimulus(7'h2B);
        apply_stimulus(7'h39);
        apply_stimulus(7'h3D);
        check_output("t3b_op_valid", {6'd0, op_valid}, 7'd1);
        check_output("t3b_AU", AU, 7'h39);
        check_output("t3b_AD", AD, 7'h30);
        check_output("t3b_BU", BU, 7'h39);
        check_output("t3b_BD", BD, 7'h30);
        take_operands();

        // Leading '+' errors; junk and digits are skipped silently until '='
        apply_stimulus(7'h2B);
        check_output("t4_err_plus", {6'd0, err}, 7'd1);
        apply_stimulus(7'h78);
        check_output("t4_err_x", {6'd0, err}, 7'd0);
        apply_stimulus(7'h35);
        check_output("t4_err_5", {6'd0, err}, 7'd0);
        apply_stimulus(7'h3D);
        check_output("t4_err_term", {6'd0, err}, 7'd0);
        check_output("t4_op_valid", {6'd0, op_valid}, 7'd0);
        apply_stimulus(7'h36);
        apply_stimulus(7'h2B);
        apply_stimulus(7'h37);
        apply_stimulus(7'h3D);
        check_output("t4b_op_valid", {6'd0, op_valid}, 7'd1);
        check_output("t4b_AU", AU, 7'h36);
        check_output("t4b_BU", BU, 7'h37);
        take_operands();

        // Terminator with no B digit is an error
        apply_stimulus(7'h33);
        apply_stimulus(7'h2B);
        apply_stimulus(7'h3D);
        check_output("t5_err_empty_b", {6'd0, err}, 7'd1);
        check_output("t5_op_valid", {6'd0, op_valid}, 7'd0);
        apply_stimulus(7'h3D);
        check_output("t5_resync_err", {6'd0, err}, 7'd0);

        // Reset mid-expression discards "45+" without err
        apply_stimulus(7'h34);
        apply_stimulus(7'h35);
        apply_stimulus(7'h2B);
        @(negedge clk);
        char_valid = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        check_output("t6_rst_err", {6'd0, err}, 7'd0);
        check_output("t6_rst_AU", AU, 7'h30);
        check_output("t6_rst_char_ready", {6'd0, char_ready}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(7'h31);
        apply_stimulus(7'h2B);
        check_output("t6_err_plus", {6'd0, err}, 7'd0);
        apply_stimulus(7'h32);
        apply_stimulus(7'h3D);
        check_output("t6_op_valid", {6'd0, op_valid}, 7'd1);
        check_output("t6_AU", AU, 7'h31);
        check_output("t6_BU", BU, 7'h32);
        check_output("t6_err", {6'd0, err}, 7'd0);
        take_operands();

        // Echo of "3+4=" streamed with char_valid held high
        apply_stimulus(7'h33);
        check_output("echo_v0", {6'd0, echo_valid}, {6'd0, ECHO_ON});
        check_output("echo_c0", echo_char, ECHO_ON ? 7'h33 : 7'h00);
        apply_stimulus(7'h2B);
        check_output("echo_v1", {6'd0, echo_valid}, {6'd0, ECHO_ON});
        check_output("echo_c1", echo_char, ECHO_ON ? 7'h2B : 7'h00);
        apply_stimulus(7'h34);
        check_output("echo_v2", {6'd0, echo_valid}, {6'd0, ECHO_ON});
        check_output("echo_c2", echo_char, ECHO_ON ? 7'h34 : 7'h00);
        apply_stimulus(7'h3D);
        check_output("echo_v3", {6'd0, echo_valid}, {6'd0, ECHO_ON});
        check_output("echo_c3", echo_char, ECHO_ON ? 7'h3D : 7'h00);
        check_output("echo_op_valid", {6'd0, op_valid}, 7'd1);
        idle(1);
        check_output("echo_v_idle", {6'd0, echo_valid}, 7'd0);
        check_output("echo_c_idle", echo_char, ECHO_ON ? 7'h3D : 7'h00);
        take_operands();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
